// File: rtl/brcomp_pkg.sv
// Shared types and helpers for the branch-comparator arbiter.
package brcomp_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_RESP} brarb_state_e;

   localparam int unsigned XLEN_DEF = 32;

   // Round-robin successor: (ptr + 1) mod n.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_pick #(
   parameter int unsigned N = 2,
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            valid_o
);

   logic found;

   // Scan offsets 0..N-1 from ptr_i; the first set request wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i == ((32'(ptr_i) + k) % N))) begin
               gnt_o[i] = 1'b1;
               idx_o    = IdxW'(i);
               found    = 1'b1;
            end
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/brcomp_arb.sv
// Round-robin sharing of one external branch comparator among NUM_REQ requesters.
// A transaction is accept (IDLE) -> compare (CMP, one cycle) -> respond (RESP).
module brcomp_arb
   import brcomp_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned XLEN    = XLEN_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   input  logic [NUM_REQ*XLEN-1:0] req_rs1_data_i,
   input  logic [NUM_REQ*XLEN-1:0] req_rs2_data_i,
   input  logic [NUM_REQ-1:0]      req_unsigned_i,
   output logic [NUM_REQ-1:0]      rsp_valid_o,
   input  logic [NUM_REQ-1:0]      rsp_ready_i,
   output logic                    rsp_less_o,
   output logic                    rsp_equal_o,
   output logic [XLEN-1:0]         cmp_rs1_data_o,
   output logic [XLEN-1:0]         cmp_rs2_data_o,
   output logic                    cmp_unsigned_o,
   input  logic                    cmp_less_i,
   input  logic                    cmp_equal_i
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   brarb_state_e    state_q;
   logic [IdxW-1:0] rr_ptr_q;
   logic [IdxW-1:0] owner_q;
   logic [XLEN-1:0] rs1_q;
   logic [XLEN-1:0] rs2_q;
   logic            uns_q;
   logic            less_q;
   logic            equal_q;

   logic [NUM_REQ-1:0] gnt;
   logic [IdxW-1:0]    win_idx;
   logic               any_req;
   logic [XLEN-1:0]    win_rs1;
   logic [XLEN-1:0]    win_rs2;
   logic               win_uns;
   logic               accept;
   logic               rsp_done;

   rr_pick #(
      .N (NUM_REQ)
   ) u_rr_pick (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (gnt),
      .idx_o   (win_idx),
      .valid_o (any_req)
   );

   // One-hot mux of the winning requester's operands.
   always_comb begin
      win_rs1 = '0;
      win_rs2 = '0;
      win_uns = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            win_rs1 = req_rs1_data_i[i*XLEN +: XLEN];
            win_rs2 = req_rs2_data_i[i*XLEN +: XLEN];
            win_uns = req_unsigned_i[i];
         end
      end
   end

   // Handshake qualifiers; flush blocks both acceptance and completion.
   always_comb begin
      accept   = (state_q == ST_IDLE) && !flush_i && any_req;
      rsp_done = (state_q == ST_RESP) && !flush_i && rsp_ready_i[owner_q];
   end

   // Sequencer: operand latch, one compare cycle, held response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         uns_q    <= 1'b0;
         less_q   <= 1'b0;
         equal_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  rs1_q   <= win_rs1;
                  rs2_q   <= win_rs2;
                  uns_q   <= win_uns;
                  owner_q <= win_idx;
                  state_q <= ST_CMP;
               end
            end
            ST_CMP: begin
               if (flush_i) begin
                  state_q <= ST_IDLE;
               end else begin
                  // Strict less: equality overrides a stray less indication.
                  less_q  <= cmp_less_i & ~cmp_equal_i;
                  equal_q <= cmp_equal_i;
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (flush_i) begin
                  state_q <= ST_IDLE;
               end else if (rsp_done) begin
                  rr_ptr_q <= IdxW'(rr_next(32'(owner_q), NUM_REQ));
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Ready is the live grant in IDLE; rst_ni keeps it low during reset.
   always_comb begin
      req_ready_o = '0;
      if ((state_q == ST_IDLE) && !flush_i && rst_ni) begin
         req_ready_o = gnt;
      end
   end

   // Response valid goes only to the owner, suppressed by flush.
   always_comb begin
      rsp_valid_o = '0;
      if ((state_q == ST_RESP) && !flush_i) begin
         rsp_valid_o[owner_q] = 1'b1;
      end
   end

   assign rsp_less_o     = less_q;
   assign rsp_equal_o    = equal_q;
   assign cmp_rs1_data_o = rs1_q;
   assign cmp_rs2_data_o = rs2_q;
   assign cmp_unsigned_o = uns_q;

endmodule

// File: tb/tb_brcomp_arb.sv
// Directed bench for brcomp_arb with a behavioural comparator attached.
module tb_brcomp_arb;

   localparam int unsigned N = 2;
   localparam int unsigned W = 32;

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b0;
   logic           flush_i = 1'b0;
   logic [N-1:0]   req_valid_i = '0;
   logic [N-1:0]   req_ready_o;
   logic [N*W-1:0] req_rs1_data_i = '0;
   logic [N*W-1:0] req_rs2_data_i = '0;
   logic [N-1:0]   req_unsigned_i = '0;
   logic [N-1:0]   rsp_valid_o;
   logic [N-1:0]   rsp_ready_i = '0;
   logic           rsp_less_o;
   logic           rsp_equal_o;
   logic [W-1:0]   cmp_rs1_data_o;
   logic [W-1:0]   cmp_rs2_data_o;
   logic           cmp_unsigned_o;
   logic           cmp_less_i;
   logic           cmp_equal_i;

   int n_vec = 0;
   int n_err = 0;

   brcomp_arb #(
      .NUM_REQ (N),
      .XLEN    (W)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_rs1_data_i (req_rs1_data_i),
      .req_rs2_data_i (req_rs2_data_i),
      .req_unsigned_i (req_unsigned_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .rsp_less_o     (rsp_less_o),
      .rsp_equal_o    (rsp_equal_o),
      .cmp_rs1_data_o (cmp_rs1_data_o),
      .cmp_rs2_data_o (cmp_rs2_data_o),
      .cmp_unsigned_o (cmp_unsigned_o),
      .cmp_less_i     (cmp_less_i),
      .cmp_equal_i    (cmp_equal_i)
   );

   // External comparator stand-in.
   assign cmp_equal_i = (cmp_rs1_data_o == cmp_rs2_data_o);
   assign cmp_less_i  = cmp_unsigned_o ? (cmp_rs1_data_o < cmp_rs2_data_o)
                                       : ($signed(cmp_rs1_data_o) < $signed(cmp_rs2_data_o));

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic u);
      req_rs1_data_i[r*W +: W] = a;
      req_rs2_data_i[r*W +: W] = b;
      req_unsigned_i[r]        = u;
   endtask

   // Lone request from r, response accepted immediately.
   task automatic single(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic u, input logic exp_lt, input logic exp_eq);
      logic [N-1:0] oh;
      oh = '0;
      oh[r] = 1'b1;
      set_req(r, a, b, u);
      req_valid_i = oh;
      rsp_ready_i = oh;
      #1;
      check("ready_idle", req_ready_o, oh);
      step();
      req_valid_i = '0;
      check("cmp_no_valid", rsp_valid_o, '0);
      check("cmp_rs1", cmp_rs1_data_o, a);
      check("cmp_uns", cmp_unsigned_o, u);
      step();
      check("rsp_valid", rsp_valid_o, oh);
      check("rsp_less", rsp_less_o, exp_lt);
      check("rsp_equal", rsp_equal_o, exp_eq);
      step();
      check("rsp_done", rsp_valid_o, '0);
      rsp_ready_i = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check("rst_ready", req_ready_o, '0);
      check("rst_rsp_valid", rsp_valid_o, '0);
      check("rst_less", rsp_less_o, 0);
      check("rst_equal", rsp_equal_o, 0);
      check("rst_cmp_rs1", cmp_rs1_data_o, 0);
      check("rst_cmp_uns", cmp_unsigned_o, 0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      step();

      // Signed / unsigned / equal directed vectors; ends with rr_ptr back at 0.
      single(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
      single(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
      single(1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
      single(1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
      single(1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);

      // Contention: grants alternate 0,1,0,1, three cycles each.
      set_req(0, 32'd5, 32'd7, 1'b0);
      set_req(1, 32'd7, 32'd5, 1'b0);
      req_valid_i = 2'b11;
      rsp_ready_i = 2'b11;
      #1;
      for (int n = 0; n < 4; n++) begin
         logic [N-1:0] oh;
         oh = (n % 2 == 0) ? 2'b01 : 2'b10;
         check("rr_ready", req_ready_o, oh);
         step();
         check("rr_cmp_idle", rsp_valid_o, '0);
         step();
         check("rr_rsp_valid", rsp_valid_o, oh);
         check("rr_rsp_less", rsp_less_o, (n % 2 == 0) ? 1 : 0);
         step();
      end
      req_valid_i = '0;
      rsp_ready_i = '0;

      // Backpressure on requester 1; requester 0 waits.
      set_req(1, 32'd3, 32'd9, 1'b1);
      req_valid_i = 2'b10;
      #1;
      check("bp_ready", req_ready_o, 2'b10);
      step();
      req_valid_i = 2'b01;
      check("bp_cmp_ready", req_ready_o, '0);
      step();
      rsp_ready_i = 2'b01;
      for (int c = 0; c < 5; c++) begin
         check("bp_valid_hold", rsp_valid_o, 2'b10);
         check("bp_less_hold", rsp_less_o, 1);
         check("bp_eq_hold", rsp_equal_o, 0);
         check("bp_no_accept", req_ready_o, '0);
         step();
      end
      rsp_ready_i = 2'b10;
      #1;
      check("bp_release_valid", rsp_valid_o, 2'b10);
      step();
      rsp_ready_i = '0;
      check("bp_after_ready", req_ready_o, 2'b01);

      // Flush in RESP for requester 0; pointer must stay at 0.
      step();
      req_valid_i = '0;
      step();
      check("fl_pre_valid", rsp_valid_o, 2'b01);
      flush_i     = 1'b1;
      rsp_ready_i = 2'b01;
      #1;
      check("fl_valid_forced", rsp_valid_o, '0);
      step();
      rsp_ready_i = '0;
      req_valid_i = 2'b11;
      #1;
      check("fl_idle_ready", req_ready_o, '0);
      flush_i = 1'b0;
      #1;
      check("fl_regrant0", req_ready_o, 2'b01);

      // Async reset mid-CMP, off the clock edge.
      step();
      req_valid_i = '0;
      #2 rst_ni = 1'b0;
      #1;
      check("ar_valid", rsp_valid_o, '0);
      check("ar_cmp_rs1", cmp_rs1_data_o, 0);
      check("ar_less", rsp_less_o, 0);
      step();
      #3 rst_ni = 1'b1;
      rsp_ready_i = 2'b11;
      step();
      check("ar_no_stale", rsp_valid_o, '0);
      step();
      check("ar_no_stale2", rsp_valid_o, '0);
      req_valid_i = 2'b11;
      #1;
      check("ar_regrant0", req_ready_o, 2'b01);
      step();
      req_valid_i = '0;
      step();
      check("ar_rsp_owner0", rsp_valid_o, 2'b01);
      step();
      rsp_ready_i = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
